// File: rtl/axi_to_cbus.sv
// axi_to_cbus: AXI3 slave that stages one whole burst locally and replays it as a cbus transaction.

package axi_to_cbus_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned ID_W   = 4;

  typedef logic [LEN_W-1:0] mlen_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    mlen_t             len;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } beat_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_BUS  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_BUS  = 3'd4,
    ST_WR_RESP = 3'd5
  } state_t;
endpackage

module axi_to_cbus
  import axi_to_cbus_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [SIZE_W-1:0] arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [SIZE_W-1:0] awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output cbus_req_t         creq,
  input  cbus_resp_t        cresp
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  mlen_t             len_q;
  logic [SIZE_W-1:0] size_q;
  mlen_t             idx;
  logic              wr_err;
  beat_t             beat_buf [BUF_DEPTH];

  logic ar_fire;
  logic aw_fire;
  logic rd_beat;
  logic wr_beat;
  logic r_fire;
  logic wb_fire;
  logic idx_at_len;

  // Handshake qualifiers shared by the datapath registers
  always_comb begin
    idx_at_len = (idx == len_q);
    ar_fire    = (state == ST_IDLE) && arvalid;
    aw_fire    = (state == ST_IDLE) && awvalid && !arvalid;
    rd_beat    = (state == ST_RD_BUS) && cresp.ready;
    wr_beat    = (state == ST_WR_DATA) && wvalid;
    r_fire     = (state == ST_RD_RESP) && rready;
    wb_fire    = (state == ST_WR_BUS) && cresp.ready;
  end

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state decode; reads win a simultaneous AR/AW
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (arvalid)      state_next = ST_RD_BUS;
        else if (awvalid) state_next = ST_WR_DATA;
      end
      ST_RD_BUS:  if (cresp.ready && cresp.last) state_next = ST_RD_RESP;
      ST_RD_RESP: if (rready && idx_at_len)      state_next = ST_IDLE;
      ST_WR_DATA: if (wvalid && idx_at_len)      state_next = ST_WR_BUS;
      ST_WR_BUS:  if (cresp.ready && cresp.last) state_next = ST_WR_RESP;
      ST_WR_RESP: if (bready)                    state_next = ST_IDLE;
      default:                                   state_next = ST_IDLE;
    endcase
  end

  // Beat index and write-protocol error flag
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx    <= '0;
      wr_err <= 1'b0;
    end else begin
      if (ar_fire || aw_fire)     idx <= '0;
      else if (rd_beat)           idx <= cresp.last ? '0 : idx + mlen_t'(1);
      else if (wr_beat)           idx <= idx_at_len ? '0 : idx + mlen_t'(1);
      else if (r_fire || wb_fire) idx <= idx + mlen_t'(1);

      if (aw_fire)                                wr_err <= 1'b0;
      else if (wr_beat && (wlast != idx_at_len))  wr_err <= 1'b1;
    end
  end

  // Captured address-phase fields and the burst staging buffer
  always_ff @(posedge aclk) begin
    if (ar_fire) begin
      id_q   <= arid;
      addr_q <= araddr;
      len_q  <= arlen;
      size_q <= arsize;
    end else if (aw_fire) begin
      id_q   <= awid;
      addr_q <= awaddr;
      len_q  <= awlen;
      size_q <= awsize;
    end
    if (rd_beat)      beat_buf[idx] <= {cresp.data, STRB_W'(0)};
    else if (wr_beat) beat_buf[idx] <= {wdata, wstrb};
  end

  // Output decode from the registered state
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rid     = id_q;
    rdata   = beat_buf[idx].data;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = id_q;
    bresp   = wr_err ? RESP_SLVERR : RESP_OKAY;
    creq    = '0;
    case (state)
      ST_IDLE: begin
        arready = 1'b1;
        awready = !arvalid;
      end
      ST_RD_BUS: begin
        creq.valid = 1'b1;
        creq.addr  = addr_q;
        creq.len   = len_q;
        creq.size  = size_q;
      end
      ST_RD_RESP: begin
        rvalid = 1'b1;
        rlast  = idx_at_len;
      end
      ST_WR_DATA: wready = 1'b1;
      ST_WR_BUS: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = addr_q;
        creq.len      = len_q;
        creq.size     = size_q;
        creq.data     = beat_buf[idx].data;
        creq.strobe   = beat_buf[idx].strb;
      end
      ST_WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  // Inputs with no function in this bridge
  logic unused_ok;
  assign unused_ok = ^{wid, arburst, awburst};

endmodule

// File: tb/tb_axi_to_cbus.sv
// tb_axi_to_cbus: randomized bench with a transaction-level model of the AXI-to-cbus bridge.

module tb_axi_to_cbus;
  import axi_to_cbus_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arvalid; logic arready;
  logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awvalid; logic awready;
  logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;
  cbus_req_t   creq;
  cbus_resp_t  cresp;

  axi_to_cbus #(.BUF_DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .creq(creq), .cresp(cresp)
  );

  // Expected cbus beats, R beats and B responses, in order
  typedef struct {
    bit          w;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          last;
    logic [31:0] rdat;
  } req_t;
  typedef struct { logic [3:0] id; logic [31:0] data; bit last; } rb_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bb_t;

  req_t        exp_req_q [$];
  rb_t         exp_r_q   [$];
  bb_t         exp_b_q   [$];
  logic [31:0] wr_log    [$];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  bit          wl [16];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Model: a read returns one responder word per beat, replayed in order on R
  function automatic void model_read(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [3:0] len, input logic [2:0] size,
                                     input bit fixed, input logic [31:0] fdata);
    req_t e; rb_t r; logic [31:0] d;
    for (int k = 0; k <= int'(len); k++) begin
      d = fixed ? fdata + 32'(k) : $urandom;
      e.w = 1'b0; e.size = size; e.addr = addr; e.len = len; e.data = '0; e.strb = '0;
      e.last = (4'(k) == len); e.rdat = d;
      exp_req_q.push_back(e);
      r.id = id; r.data = d; r.last = (4'(k) == len);
      exp_r_q.push_back(r);
    end
  endfunction

  // Model: a write replays the len+1 W beats; any misplaced wlast gives SLVERR
  function automatic void model_write(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [3:0] len, input logic [2:0] size);
    req_t e; bb_t b; bit err;
    err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      e.w = 1'b1; e.size = size; e.addr = addr; e.len = len; e.data = wd[k]; e.strb = ws[k];
      e.last = (4'(k) == len); e.rdat = '0;
      exp_req_q.push_back(e);
      if (wl[k] != (4'(k) == len)) err = 1'b1;
    end
    b.id = id; b.resp = err ? 2'b10 : 2'b00;
    exp_b_q.push_back(b);
  endfunction

  bit          chk_en = 1'b0;
  int          rsp_mode = 0;
  bit          alt = 1'b1;
  logic        prev_hold = 1'b0, prev_rstn = 1'b0, prev_rvalid = 1'b0, prev_rready = 1'b0;
  logic        prev_bvalid = 1'b0, prev_creq_valid = 1'b0;
  logic [31:0] prev_rdata = '0;
  int          first_req_cyc = 0, first_r_cyc = 0, first_b_cyc = 0, req_last_cyc = 0, r_done_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic [3:0]  last_rid = '0, last_bid = '0;
  logic [1:0]  last_bresp = '0;

  // Compare process plus cbus responder, evaluated mid-cycle
  always @(negedge aclk) begin : cmp
    req_t e; rb_t r; bb_t b; bit rdy;
    cresp.ready = 1'b0;
    cresp.last  = 1'b0;
    cresp.data  = $urandom;
    if (chk_en) begin
      if (prev_hold && prev_rstn) chk("creq_held", 64'(creq.valid), 64'(1));
      if (prev_rvalid && !prev_rready && prev_rstn) begin
        chk("rvalid_held", 64'(rvalid), 64'(1));
        chk("rdata_stable", 64'(rdata), 64'(prev_rdata));
      end
      if (creq.valid) begin
        if (!prev_creq_valid) first_req_cyc = cyc;
        if (exp_req_q.size() == 0) chk("creq_unexpected", 64'(creq.valid), 64'(0));
        else begin
          e = exp_req_q[0];
          chk("creq_is_write", 64'(creq.is_write), 64'(e.w));
          chk("creq_addr",     64'(creq.addr),     64'(e.addr));
          chk("creq_len",      64'(creq.len),      64'(e.len));
          chk("creq_size",     64'(creq.size),     64'(e.size));
          chk("creq_data",     64'(creq.data),     64'(e.data));
          chk("creq_strobe",   64'(creq.strobe),   64'(e.strb));
          case (rsp_mode)
            0:       rdy = 1'b1;
            1:       begin rdy = alt; alt = !alt; end
            default: rdy = 1'($urandom_range(0, 1));
          endcase
          if (rdy) begin
            cresp.ready = 1'b1;
            cresp.last  = e.last;
            if (!e.w) cresp.data = e.rdat;
            else      wr_log.push_back(creq.data);
            if (e.last) req_last_cyc = cyc;
            void'(exp_req_q.pop_front());
          end
        end
      end
      if (rvalid) begin
        if (!prev_rvalid) first_r_cyc = cyc;
        if (exp_r_q.size() == 0) chk("r_unexpected", 64'(rvalid), 64'(0));
        else begin
          r = exp_r_q[0];
          chk("rid",   64'(rid),   64'(r.id));
          chk("rdata", 64'(rdata), 64'(r.data));
          chk("rlast", 64'(rlast), 64'(r.last));
          chk("rresp", 64'(rresp), 64'(0));
          if (rready) begin
            void'(exp_r_q.pop_front());
            if (rlast) begin
              r_done_cyc = cyc; last_rdata = rdata; last_rid = rid;
            end
          end
        end
      end
      if (bvalid) begin
        if (!prev_bvalid) first_b_cyc = cyc;
        if (exp_b_q.size() == 0) chk("b_unexpected", 64'(bvalid), 64'(0));
        else begin
          b = exp_b_q[0];
          chk("bid",   64'(bid),   64'(b.id));
          chk("bresp", 64'(bresp), 64'(b.resp));
          if (bready) begin
            void'(exp_b_q.pop_front());
            last_bid = bid; last_bresp = bresp;
          end
        end
      end
    end
    if (!aresetn) begin
      exp_req_q.delete(); exp_r_q.delete(); exp_b_q.delete();
    end
    prev_hold       = creq.valid && !(cresp.ready && cresp.last);
    prev_rstn       = aresetn;
    prev_rvalid     = rvalid;
    prev_rready     = rready;
    prev_rdata      = rdata;
    prev_creq_valid = creq.valid;
    prev_bvalid     = bvalid;
  end

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, output int t);
    bit hs;
    hs = 1'b0; t = -1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
    for (int n = 0; n < 400 && !hs; n++) begin
      @(negedge aclk);
      if (arready) begin hs = 1'b1; t = cyc; end
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 64'(0), 64'(1));
  endtask

  task automatic r_collect(input int mode);
    bit done; int k;
    done = 1'b0; k = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (rvalid) begin
        case (mode)
          0:       rready = 1'b1;
          1:       rready = (k % 2 == 0);
          default: rready = 1'($urandom_range(0, 1));
        endcase
        k++;
      end else rready = 1'b0;
      @(negedge aclk);
      if (rvalid && rready && rlast) done = 1'b1;
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    if (!done) chk("r_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input bit fixed, input logic [31:0] fdata,
                         input int mode, output int t);
    model_read(id, addr, len, size, fixed, fdata);
    ar_hs(id, addr, len, size, t);
    r_collect(mode);
  endtask

  task automatic w_all(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input bit gaps, input int bmode,
                       output int t_aw, output int t_lw, output int aw_wait);
    bit hs; bit done;
    hs = 1'b0; t_aw = -1; t_lw = -1; aw_wait = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    for (int n = 0; n < 400 && !hs; n++) begin
      @(negedge aclk);
      if (awready) begin hs = 1'b1; t_aw = cyc; end
      else aw_wait++;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 64'(0), 64'(1));
    for (int b = 0; b <= int'(len) && hs; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wdata = wd[b]; wstrb = ws[b]; wlast = wl[b]; wid = 4'($urandom); wvalid = 1'b1;
      hs = 1'b0;
      for (int n = 0; n < 100 && !hs; n++) begin
        @(negedge aclk);
        if (wready) begin hs = 1'b1; t_lw = cyc; end
        @(posedge aclk); #1;
      end
      if (!hs) chk("w_timeout", 64'(0), 64'(1));
    end
    wvalid = 1'b0; wlast = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (bvalid && bready) done = 1'b1;
      @(posedge aclk); #1;
    end
    bready = 1'b0;
    if (!done) chk("b_timeout", 64'(0), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t, t_aw, t_lw, aw_wait;
    logic [31:0] lit [4];
    logic [3:0] len;
    int fl;

    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge aclk);
    chk("rst_arready",    64'(arready),    64'(1));
    chk("rst_awready",    64'(awready),    64'(1));
    chk("rst_creq_valid", 64'(creq.valid), 64'(0));
    chk("rst_rvalid",     64'(rvalid),     64'(0));
    chk("rst_bvalid",     64'(bvalid),     64'(0));
    chk("rst_wready",     64'(wready),     64'(0));
    @(posedge aclk); #1;

    // 1: single read, zero-wait responder
    rsp_mode = 0;
    do_read(4'd3, 32'h100, 4'd0, 3'd2, 1'b1, 32'hDEADBEEF, 0, t);
    chk("t1_rdata",     64'(last_rdata),    64'(32'hDEADBEEF));
    chk("t1_rid",       64'(last_rid),      64'(4'd3));
    chk("t1_req_lat",   64'(first_req_cyc), 64'(t + 1));
    chk("t1_r_lat",     64'(first_r_cyc),   64'(t + 2));

    // 2: burst read len=3 with rready toggling 1,0,1,0
    do_read(4'd1, 32'h2000, 4'd3, 3'd2, 1'b1, 32'hA0, 1, t);
    chk("t2_last_rdata", 64'(last_rdata),      64'(32'hA3));
    chk("t2_r_lat",      64'(first_r_cyc),     64'(t + 5));
    chk("t2_r_drained",  64'(exp_r_q.size()),  64'(0));

    // 3: burst write len=3, responder ready every other cycle
    lit[0] = 32'h11; lit[1] = 32'h22; lit[2] = 32'h33; lit[3] = 32'h44;
    for (int k = 0; k < 4; k++) begin wd[k] = lit[k]; ws[k] = 4'hF; wl[k] = (k == 3); end
    model_write(4'd7, 32'h300, 4'd3, 3'd2);
    wr_log.delete();
    rsp_mode = 1; alt = 1'b1;
    w_all(4'd7, 32'h300, 4'd3, 3'd2, 1'b0, 0, t_aw, t_lw, aw_wait);
    chk("t3_beats", 64'(wr_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < wr_log.size(); k++) chk("t3_wdata", 64'(wr_log[k]), 64'(lit[k]));
    chk("t3_bid",   64'(last_bid),   64'(4'd7));
    chk("t3_bresp", 64'(last_bresp), 64'(2'b00));

    // 4: write len=1 with wlast on the first beat
    rsp_mode = 0;
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'h3; ws[1] = 4'hC; wl[0] = 1'b1; wl[1] = 1'b1;
    model_write(4'd2, 32'h400, 4'd1, 3'd2);
    wr_log.delete();
    w_all(4'd2, 32'h400, 4'd1, 3'd2, 1'b0, 0, t_aw, t_lw, aw_wait);
    chk("t4_beats",   64'(wr_log.size()), 64'(2));
    chk("t4_bresp",   64'(last_bresp),    64'(2'b10));
    chk("t4_req_lat", 64'(first_req_cyc), 64'(t_lw + 1));
    chk("t4_b_lat",   64'(first_b_cyc),   64'(req_last_cyc + 1));

    // 5: AR and AW presented together; read first, write afterwards
    model_read(4'd4, 32'h500, 4'd2, 3'd2, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; wl[k] = (k == 1); end
    model_write(4'd9, 32'h600, 4'd1, 3'd2);
    fork
      begin ar_hs(4'd4, 32'h500, 4'd2, 3'd2, t); r_collect(0); end
      begin w_all(4'd9, 32'h600, 4'd1, 3'd2, 1'b0, 0, t_aw, t_lw, aw_wait); end
    join
    chk("t5_aw_held",  64'(aw_wait > 0),  64'(1));
    chk("t5_aw_after", 64'(t_aw),         64'(r_done_cyc + 1));
    chk("t5_bid",      64'(last_bid),     64'(4'd9));

    // 6: reset during beat 2 of a 4-beat read bus phase
    model_read(4'd5, 32'h800, 4'd3, 3'd2, 1'b0, 32'h0);
    ar_hs(4'd5, 32'h800, 4'd3, 3'd2, t);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("t6_creq_valid", 64'(creq.valid), 64'(0));
    chk("t6_arready",    64'(arready),    64'(1));
    chk("t6_awready",    64'(awready),    64'(1));
    chk("t6_rvalid",     64'(rvalid),     64'(0));
    @(posedge aclk); #1;
    do_read(4'd6, 32'h700, 4'd3, 3'd2, 1'b1, 32'h70000000, 0, t);
    chk("t6_rdata_after", 64'(last_rdata), 64'(32'h70000003));
    chk("t6_rid_after",   64'(last_rid),   64'(4'd6));

    // Randomized mix of reads and writes
    for (int i = 0; i < 40; i++) begin
      rsp_mode = $urandom_range(0, 2);
      len = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_read(4'($urandom), $urandom, len, 3'($urandom), 1'b0, 32'h0, $urandom_range(0, 2), t);
      end else begin
        for (int k = 0; k < 16; k++) begin
          wd[k] = $urandom; ws[k] = 4'($urandom); wl[k] = (4'(k) == len);
        end
        if ($urandom_range(0, 6) == 0) begin
          fl = $urandom_range(0, int'(len));
          wl[fl] = !wl[fl];
        end
        model_write(4'($urandom), $urandom, len, 3'($urandom));
        w_all(exp_b_q[exp_b_q.size()-1].id, exp_req_q[0].addr, len, exp_req_q[0].size,
              1'b1, $urandom_range(0, 1), t_aw, t_lw, aw_wait);
      end
    end

    repeat (3) @(posedge aclk);
    chk("queues_drained", 64'(exp_req_q.size() + exp_r_q.size() + exp_b_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
